// File: rtl/hpf_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : hpf_multi_seq
//  Purpose  : Cascade of ORDER first-order high-pass stages. All stages share
//             one subtract/shift/add datapath and are evaluated serially, one
//             stage per clock. Each stage keeps a low-pass state Lk:
//                 D = Xk - Lk ;  Hk = D ;  Lk <= Lk + (D >>> SHR) ;  Xk+1 = Hk
//             The final stage output is scaled back by SHR and saturated to
//             DATA_W bits. ORDER = 0 degenerates to a registered bypass.
//  Ports    : clk_i    - clock, rising edge
//             rst_n_i  - synchronous active-low reset
//             en_i     - sample strobe, taken when ready_o is high
//             data_i   - signed input sample
//             clr_i    - clears the sticky ovr_o / sat_o flags
//             ready_o  - a new sample can be accepted this cycle
//             valid_o  - one-cycle pulse qualifying hp_o
//             hp_o     - signed high-pass output, held between pulses
//             ovr_o    - sticky: a sample was offered while busy
//             sat_o    - sticky: an output value was clipped
//  Revision : 1.0 - initial release
// ============================================================================
module hpf_multi_seq #(
    parameter int DATA_W = 32,
    parameter int SHR    = 16,
    parameter int ORDER  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     clr_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic signed [DATA_W-1:0] hp_o,
    output logic                     ovr_o,
    output logic                     sat_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Hooks from the selected datapath into the shared output registers.
    logic                     w_hp_load;
    logic signed [DATA_W-1:0] w_hp_next;
    logic                     w_ovr_set;
    logic                     w_sat_set;

    generate
        if (ORDER == 0) begin : g_bypass
            // No filtering: every strobe is accepted and echoed next cycle.
            assign ready_o   = 1'b1;
            assign w_hp_load = en_i;
            assign w_hp_next = data_i;
            assign w_ovr_set = 1'b0;
            assign w_sat_set = 1'b0;
        end else begin : g_filter
            // Headroom: SHR fractional bits, one growth bit per stage, sign.
            localparam int ACCUM_W = DATA_W + SHR + ORDER + 1;
            localparam int K_W     = (ORDER > 1) ? $clog2(ORDER) : 1;
            localparam logic [K_W-1:0] c_last_stage = K_W'(ORDER - 1);
            localparam logic signed [DATA_W-1:0] c_hp_max = {1'b0, {(DATA_W-1){1'b1}}};
            localparam logic signed [DATA_W-1:0] c_hp_min = {1'b1, {(DATA_W-1){1'b0}}};

            state_t                     r_state;
            state_t                     w_state_next;
            logic [K_W-1:0]             r_k;
            logic signed [ACCUM_W-1:0]  r_x;
            logic signed [ACCUM_W-1:0]  r_l [ORDER];

            logic                       w_accept;
            logic                       w_step;
            logic                       w_last;
            logic signed [ACCUM_W-1:0]  w_x_ext;
            logic signed [ACCUM_W-1:0]  w_x0;
            logic signed [ACCUM_W-1:0]  w_d;
            logic signed [ACCUM_W-1:0]  w_h_sh;
            logic signed [DATA_W-1:0]   w_h_trunc;
            logic                       w_clip;

            assign w_last = (r_k == c_last_stage);

            // ---------------- FSM state register ----------------
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_state <= IDLE;
                end else begin
                    r_state <= w_state_next;
                end
            end

            // ---------------- FSM next state / controls ----------------
            always_comb begin
                w_state_next = r_state;
                w_accept     = 1'b0;
                w_step       = 1'b0;
                case (r_state)
                    IDLE: begin
                        if (en_i) begin
                            w_accept     = 1'b1;
                            w_state_next = RUN;
                        end
                    end
                    RUN: begin
                        w_step = 1'b1;
                        if (w_last) begin
                            w_state_next = DONE;
                        end
                    end
                    DONE:    w_state_next = IDLE;
                    default: w_state_next = IDLE;
                endcase
            end

            assign ready_o   = (r_state == IDLE);
            // Any strobe outside IDLE is dropped and flagged.
            assign w_ovr_set = en_i && (r_state != IDLE);

            // ---------------- shared stage datapath ----------------
            assign w_x_ext   = {{(ACCUM_W-DATA_W){data_i[DATA_W-1]}}, data_i};
            assign w_x0      = w_x_ext <<< SHR;
            assign w_d       = r_x - r_l[r_k];
            assign w_h_sh    = w_d >>> SHR;
            assign w_h_trunc = w_h_sh[DATA_W-1:0];
            // Clipping is needed whenever the truncated value does not
            // sign-extend back to the full-width result.
            assign w_clip    = (w_h_sh != {{(ACCUM_W-DATA_W){w_h_trunc[DATA_W-1]}}, w_h_trunc});

            // hp_o is loaded on the last RUN edge so that it is already
            // visible during the DONE cycle together with valid_o.
            assign w_hp_load = w_step && w_last;
            assign w_hp_next = w_clip ? (w_h_sh[ACCUM_W-1] ? c_hp_min : c_hp_max) : w_h_trunc;
            assign w_sat_set = w_hp_load && w_clip;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_k <= '0;
                    r_x <= '0;
                    for (int i = 0; i < ORDER; i++) begin
                        r_l[i] <= '0;
                    end
                end else begin
                    if (w_accept) begin
                        r_x <= w_x0;
                        r_k <= '0;
                    end
                    if (w_step) begin
                        r_x      <= w_d;
                        r_l[r_k] <= r_l[r_k] + w_h_sh;
                        r_k      <= w_last ? '0 : r_k + K_W'(1);
                    end
                end
            end
        end
    endgenerate

    // ---------------- output and sticky flag registers ----------------
    // A set event in the same cycle as clr_i keeps the flag high.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hp_o    <= '0;
            valid_o <= 1'b0;
            ovr_o   <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= w_hp_load;
            if (w_hp_load) begin
                hp_o <= w_hp_next;
            end
            ovr_o <= w_ovr_set | (ovr_o & ~clr_i);
            sat_o <= w_sat_set | (sat_o & ~clr_i);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hpf_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpf_multi_seq
//  Purpose  : Self-checking bench for hpf_multi_seq (DATA_W=16, SHR=4,
//             ORDER=2 plus an ORDER=0 instance). Table vectors, hand-written
//             timing sequences and random samples against a division-based
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hpf_multi_seq;

    localparam int DATA_W = 16;
    localparam int SHR    = 4;
    localparam int ORDER  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n, en, clr, en0;
    logic signed [DATA_W-1:0] data, data0;
    logic                     ready, valid, ovr, sat;
    logic signed [DATA_W-1:0] hp;
    logic                     ready0, valid0, ovr0, sat0;
    logic signed [DATA_W-1:0] hp0;

    hpf_multi_seq #(.DATA_W(DATA_W), .SHR(SHR), .ORDER(ORDER)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .clr_i(clr),
        .ready_o(ready), .valid_o(valid), .hp_o(hp), .ovr_o(ovr), .sat_o(sat)
    );

    hpf_multi_seq #(.DATA_W(DATA_W), .SHR(SHR), .ORDER(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en0), .data_i(data0), .clr_i(clr),
        .ready_o(ready0), .valid_o(valid0), .hp_o(hp0), .ovr_o(ovr0), .sat_o(sat0)
    );

    typedef struct {
        bit rst;
        int din;
        int exp_hp;
        bit exp_sat;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint ml [ORDER];
    bit     m_sat, m_ovr;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Floor division (rounds toward minus infinity).
    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ORDER; k++) ml[k] = 0;
        m_sat = 0;
        m_ovr = 0;
    endtask

    // One accepted sample through the whole cascade.
    task automatic model_step(input longint din, output longint out);
        longint scale, x, d, h;
        scale = longint'(1) << SHR;
        x = din * scale;
        for (int k = 0; k < ORDER; k++) begin
            d     = x - ml[k];
            ml[k] = ml[k] + fdiv(d, scale);
            x     = d;
        end
        h = fdiv(x, scale);
        if (h > 32767) begin
            out = 32767; m_sat = 1;
        end else if (h < -32768) begin
            out = -32768; m_sat = 1;
        end else begin
            out = h;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; clr = 0; en0 = 0; data = '0; data0 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
        @(negedge clk);
    endtask

    // Offer one sample, optionally poke en_i while busy, check the result.
    task automatic send(input int din, input bit poke, output longint got);
        int     g;
        int     lat;
        longint exp;
        g = 0;
        while (!ready && g < 12) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_send", ready, 1);
        en = 1; data = 16'(din);
        model_step(din, exp);
        @(negedge clk);
        en = 0;
        lat = 1;
        while (!valid && lat < 12) begin
            en = poke && ($urandom_range(0, 2) == 0);
            if (en) begin
                data  = 16'($urandom);
                m_ovr = 1;
            end
            @(negedge clk);
            lat++;
        end
        en = 0;
        got = hp;
        chk("latency", lat, ORDER + 1);
        chk("hp", hp, exp);
        chk("sat", sat, m_sat);
        chk("ovr", ovr, m_ovr);
    endtask

    initial begin
        longint                   got, exp;
        int                       vcount, g;
        logic signed [DATA_W-1:0] r16;
        vec_t                     tbl [6];

        rst_n = 0; en = 0; clr = 0; en0 = 0; data = '0; data0 = '0;
        do_reset();

        // Reset state
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_hp", hp, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_sat", sat, 0);

        // First sample: cycle-by-cycle timing
        en = 1; data = 16'sd1000;
        model_step(1000, exp);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            en = 0;
            chk("first_ready", ready, (c >= 4));
            chk("first_valid", valid, (c == 3));
            if (c == 3) chk("first_hp", hp, 1000);
        end

        // Table vectors (hand-computed expectations)
        tbl[0] = '{1'b1,   1000,   1000, 1'b0};
        tbl[1] = '{1'b0,   1000,    875, 1'b0};
        tbl[2] = '{1'b0,      0,   -239, 1'b0};
        tbl[3] = '{1'b0,   -500,   -716, 1'b0};
        tbl[4] = '{1'b1,  32767,  32767, 1'b0};
        tbl[5] = '{1'b0, -32768, -32768, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) do_reset();
            send(tbl[i].din, 1'b0, got);
            chk("tbl_hp", got, tbl[i].exp_hp);
            chk("tbl_sat", sat, tbl[i].exp_sat);
        end
        clr = 1;
        @(negedge clk);
        clr = 0; m_sat = 0;
        chk("sat_clr", sat, 0);

        // Overrun: second strobe while busy is dropped
        do_reset();
        en = 1; data = 16'sd1000;
        model_step(1000, exp);
        @(negedge clk);
        data = 16'sd2000;
        chk("ovr_n1", ovr, 0);
        chk("ovr_valid_n1", valid, 0);
        @(negedge clk);
        en = 0; m_ovr = 1;
        vcount = 0;
        got = 0;
        for (int c = 2; c <= 8; c++) begin
            if (valid) begin
                vcount++;
                got = hp;
            end
            if (c == 2) chk("ovr_set", ovr, 1);
            @(negedge clk);
        end
        chk("ovr_one_valid", vcount, 1);
        chk("ovr_hp", got, exp);
        clr = 1;
        @(negedge clk);
        clr = 0; m_ovr = 0;
        chk("ovr_clr", ovr, 0);
        // clr_i and a dropped strobe in the same cycle: flag stays set
        en = 1; data = 16'sd0;
        model_step(0, exp);
        @(negedge clk);
        clr = 1; data = 16'sd123;
        @(negedge clk);
        en = 0; clr = 0; m_ovr = 1;
        chk("ovr_clr_race", ovr, 1);
        g = 0;
        while (!valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("race_valid", valid, 1);
        chk("race_hp", hp, exp);

        // Reset in the middle of RUN aborts the sample
        do_reset();
        send(300, 1'b0, got);
        @(negedge clk);
        en = 1; data = 16'sd1234;
        @(negedge clk);
        data = 16'sd777; rst_n = 0;
        @(negedge clk);
        en = 0; rst_n = 1;
        model_reset();
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (valid) vcount++;
            @(negedge clk);
        end
        chk("midrun_no_valid", vcount, 0);
        chk("midrun_hp", hp, 0);
        chk("midrun_ready", ready, 1);
        send(500, 1'b0, got);
        chk("midrun_next", got, 500);

        // DC decay
        do_reset();
        got = 1;
        for (int i = 0; i < 2000; i++) send(1000, 1'b0, got);
        chk("dc_final_hp", got, 0);
        chk("dc_sat", sat, 0);

        // Random samples with random gaps, busy pokes and flag clears
        do_reset();
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                clr = 1;
                @(negedge clk);
                clr = 0; m_sat = 0; m_ovr = 0;
            end
            r16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) r16 = r16 >>> 4;
            send(int'(r16), ($urandom_range(0, 3) == 0), got);
        end

        // ORDER = 0 bypass instance
        en0 = 1; data0 = -16'sd1234;
        @(negedge clk);
        en0 = 0;
        chk("o0_valid", valid0, 1);
        chk("o0_hp", hp0, -1234);
        chk("o0_ready", ready0, 1);
        @(negedge clk);
        chk("o0_valid_pulse", valid0, 0);
        for (int i = 0; i < 8; i++) begin
            r16 = 16'($urandom);
            en0 = 1; data0 = r16;
            @(negedge clk);
            chk("o0_b2b_valid", valid0, 1);
            chk("o0_b2b_hp", hp0, r16);
            chk("o0_b2b_ready", ready0, 1);
            chk("o0_b2b_ovr", ovr0, 0);
        end
        en0 = 0;
        chk("o0_sat", sat0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got %0d errors so far, expected completion", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/hpf_multi_seq.md
HPF_MULTI_SEQ -- requirements
Module: hpf_multi_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed two's-complement I/O data width.
REQ-002 SHALL have parameter SHR, default 16, per-stage time-constant shift (pole at 1-2^-SHR).
REQ-003 SHALL have parameter ORDER, default 3, number of cascaded first-order high-pass stages (0..8).
REQ-004 SHALL have port clk_i  in  1  clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port en_i  in  1  input sample strobe, active high.
REQ-007 SHALL have port data_i  in  DATA_W  signed sample, sampled when en_i && ready_o.
REQ-008 SHALL have port clr_i  in  1  clears sticky flags ovr_o and sat_o.
REQ-009 SHALL have port ready_o  out  1  high when a new sample can be accepted.
REQ-010 SHALL have port valid_o  out  1  one-cycle pulse qualifying hp_o.
REQ-011 SHALL have port hp_o  out  DATA_W  signed high-pass output, held between valid_o pulses.
REQ-012 SHALL have port ovr_o  out  1  sticky: sample offered while busy.
REQ-013 SHALL have port sat_o  out  1  sticky: output saturated.

Function
REQ-014 SHALL compute all stages serially through one shared subtract/shift/add datapath, one stage per clock.
REQ-015 SHALL use internal width ACCUM_W = DATA_W+SHR+ORDER+1, signed; stage-0 input X0 = sign_ext(data_i) << SHR.
REQ-016 SHALL, for stage k with low-pass state Lk: D = Xk - Lk; Hk = D; Lk <= Lk + (D >>> SHR), arithmetic shift (floor); Xk+1 = Hk.
REQ-017 SHALL store ORDER states Lk in a register array; only state k is written in stage-k cycle.
REQ-018 SHALL produce hp_o = saturate(H(ORDER-1) >>> SHR) to DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 SHALL set sat_o when saturation clips a value; hp_o shows the clipped value.
REQ-020 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; ready_o = 1 only in IDLE.
REQ-021 SHALL in IDLE latch data_i and go to RUN on en_i; stage counter = 0.
REQ-022 SHALL in RUN process stage counter k, increment it, and go to DONE after k = ORDER-1.
REQ-023 SHALL in DONE register hp_o, pulse valid_o for exactly one cycle, return to IDLE.
REQ-024 SHALL give latency: en_i accepted in cycle n -> valid_o high in cycle n+ORDER+1; throughput one sample per ORDER+2 cycles.
REQ-025 SHALL ignore en_i when ready_o = 0 (sample dropped, no state change) and set ovr_o.
REQ-026 SHALL, with ORDER = 0, bypass filtering: hp_o = data_i, valid_o in cycle n+1, ready_o always 1, ovr_o never set.
REQ-027 SHALL clear ovr_o/sat_o on clr_i; a set event in the same cycle as clr_i wins (flag stays 1).
REQ-028 SHALL not alter hp_o, states, or FSM on clr_i.

Reset
REQ-029 SHALL, on rst_n_i low at a clock edge: FSM to IDLE, stage counter 0, all Lk = 0, hp_o = 0, valid_o = 0, ovr_o = 0, sat_o = 0, ready_o = 1 next cycle.
REQ-030 SHALL abort an in-progress computation on reset mid-RUN; no valid_o pulse is produced for the aborted sample.
REQ-031 SHALL ignore en_i in any cycle where rst_n_i is low.

Verification (DATA_W=16, SHR=4, ORDER=2 unless stated)
REQ-032 SHALL cover first sample: after reset en_i with data_i = 1000 at cycle n -> valid_o only at n+3, hp_o = 1000, ready_o low cycles n+1..n+3.
REQ-033 SHALL cover DC decay: constant data_i = 1000 for 2000 accepted samples -> final hp_o = 0, sat_o = 0.
REQ-034 SHALL cover saturation: after reset feed 32767 then -32768 -> outputs 32767 then -32768 (unclipped -36864), sat_o = 1; clr_i with no new clip -> sat_o = 0.
REQ-035 SHALL cover overrun: en_i at n and n+1 -> second sample dropped, ovr_o = 1 from n+2, exactly one valid_o; clr_i and drop in same cycle -> ovr_o stays 1.
REQ-036 SHALL cover reset mid-RUN: rst_n_i low at n+1 after accept at n -> no valid_o, hp_o = 0; next sample 500 -> hp_o = 500.
REQ-037 SHALL cover ORDER=0: data_i = -1234 at n -> valid_o at n+1, hp_o = -1234.
